// File: rtl/apu_pkg.sv
// Shared APU register map, frame-sequencer timing defaults and mode encoding.
package apu_pkg;

  localparam logic [5:0] APU_REG_STATUS = 6'd21;
  localparam logic [5:0] APU_REG_FRAME  = 6'd23;

  localparam int unsigned STEP1_DEF       = 3729;
  localparam int unsigned STEP2_DEF       = 7457;
  localparam int unsigned STEP3_DEF       = 11186;
  localparam int unsigned STEP4_DEF       = 14915;
  localparam int unsigned STEP5_DEF       = 18641;
  localparam int unsigned RESET_DELAY_DEF = 2;

  typedef enum logic {
    FRAME_4STEP = 1'b0,
    FRAME_5STEP = 1'b1
  } frame_mode_e;

endpackage

// File: rtl/apu_frame_sequencer.sv
// APU frame counter: quarter/half-frame clock pulses, frame IRQ flag and the
// delayed counter restart that follows a write to the frame register.
module apu_frame_sequencer
  import apu_pkg::*;
#(
  parameter int unsigned STEP1       = STEP1_DEF,
  parameter int unsigned STEP2       = STEP2_DEF,
  parameter int unsigned STEP3       = STEP3_DEF,
  parameter int unsigned STEP4       = STEP4_DEF,
  parameter int unsigned STEP5       = STEP5_DEF,
  parameter int unsigned RESET_DELAY = RESET_DELAY_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       apu_tick_i,
  input  logic [5:0] addr_i,
  input  logic [7:0] data_i,
  input  logic       write_i,
  input  logic       read_i,
  output logic       quarter_frame_o,
  output logic       half_frame_o,
  output logic       frame_irq_o,
  output logic       mode_o
);

  localparam int unsigned    DLY_W    = $clog2(RESET_DELAY + 1) + 1;
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(RESET_DELAY);
  localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);
  localparam logic [14:0]    S1 = 15'(STEP1);
  localparam logic [14:0]    S2 = 15'(STEP2);
  localparam logic [14:0]    S3 = 15'(STEP3);
  localparam logic [14:0]    S4 = 15'(STEP4);
  localparam logic [14:0]    S5 = 15'(STEP5);

  logic [14:0]      cnt;
  logic [14:0]      cnt_inc;
  frame_mode_e      mode;
  logic             inhibit;
  logic             irq_flag;
  logic             pending;
  logic [DLY_W-1:0] dly;

  logic frame_wr, status_rd;
  logic hit1, hit2, hit3, hit4, hit5;
  logic frame_end, q_step, h_step, irq_step;
  logic restart, step_tick;
  logic unused_data;

  assign frame_wr    = write_i && (addr_i == APU_REG_FRAME);
  assign status_rd   = read_i && (addr_i == APU_REG_STATUS);
  assign unused_data = ^data_i[5:0];

  // Step decoder: compares the value cnt is about to take on this tick.
  always_comb begin
    cnt_inc   = cnt + 15'd1;
    hit1      = (cnt_inc == S1);
    hit2      = (cnt_inc == S2);
    hit3      = (cnt_inc == S3);
    hit4      = (cnt_inc == S4);
    hit5      = (cnt_inc == S5);
    frame_end = (mode == FRAME_5STEP) ? hit5 : hit4;
    q_step    = hit1 | hit2 | hit3 | frame_end;
    h_step    = hit2 | frame_end;
    irq_step  = (mode == FRAME_4STEP) && hit4 && !inhibit;
    // A frame write on the expiring tick reloads the delay instead.
    restart   = pending && apu_tick_i && (dly == DLY_ONE) && !frame_wr;
    step_tick = apu_tick_i && !restart;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt             <= '0;
      mode            <= FRAME_4STEP;
      inhibit         <= 1'b0;
      irq_flag        <= 1'b0;
      pending         <= 1'b0;
      dly             <= '0;
      quarter_frame_o <= 1'b0;
      half_frame_o    <= 1'b0;
    end else begin
      quarter_frame_o <= 1'b0;
      half_frame_o    <= 1'b0;

      if (restart) begin
        cnt <= '0;
        if (mode == FRAME_5STEP) begin
          quarter_frame_o <= 1'b1;
          half_frame_o    <= 1'b1;
        end
      end else if (apu_tick_i) begin
        cnt             <= frame_end ? '0 : cnt_inc;
        quarter_frame_o <= q_step;
        half_frame_o    <= h_step;
      end

      if (frame_wr) begin
        mode    <= frame_mode_e'(data_i[7]);
        inhibit <= data_i[6];
        pending <= 1'b1;
        dly     <= DLY_LOAD;
      end else if (pending && apu_tick_i) begin
        dly <= dly - DLY_ONE;
        if (dly == DLY_ONE) pending <= 1'b0;
      end

      // Inhibit write clears outright; a step-4 set beats a status-read clear.
      if (frame_wr && data_i[6])          irq_flag <= 1'b0;
      else if (step_tick && irq_step)     irq_flag <= 1'b1;
      else if (status_rd)                 irq_flag <= 1'b0;
    end
  end

  assign frame_irq_o = irq_flag;
  assign mode_o      = mode;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Bench for apu_frame_sequencer: directed frame-timing scenarios plus random
// bus/tick traffic, all checked every clk against a position-based model.
module tb_apu_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [5:0] addr;
  logic [7:0] data;
  logic       wr, rd;
  logic       qf, hf, irq, mode;

  int checks = 0;
  int errors = 0;

  apu_frame_sequencer dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .apu_tick_i      (tick),
    .addr_i          (addr),
    .data_i          (data),
    .write_i         (wr),
    .read_i          (rd),
    .quarter_frame_o (qf),
    .half_frame_o    (hf),
    .frame_irq_o     (irq),
    .mode_o          (mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: frame position in ticks, pending restart as remaining ticks.
  localparam int STEP[5] = '{3729, 7457, 11186, 14915, 18641};
  int m_pos, m_dly;
  bit m_mode, m_inh, m_flag, e_q, e_h;

  function automatic void model_reset();
    m_pos = 0; m_dly = 0; m_mode = 0; m_inh = 0; m_flag = 0; e_q = 0; e_h = 0;
  endfunction

  function automatic void model_step(bit t, bit w, bit r, logic [5:0] a, logic [7:0] d);
    bit fw, sr, rs, set;
    int np, last;
    fw = w && (a == 6'd23);
    sr = r && (a == 6'd21);
    rs = 0; set = 0; e_q = 0; e_h = 0;
    if (!fw && t && m_dly > 0) begin
      m_dly--;
      rs = (m_dly == 0);
    end
    if (rs) begin
      m_pos = 0;
      e_q = m_mode; e_h = m_mode;
    end else if (t) begin
      np   = (m_pos + 1) % 32768;
      last = m_mode ? STEP[4] : STEP[3];
      if (np == STEP[0] || np == STEP[2]) e_q = 1;
      if (np == STEP[1]) begin e_q = 1; e_h = 1; end
      if (np == last) begin
        e_q = 1; e_h = 1;
        set = !m_mode && !m_inh;
        np = 0;
      end
      m_pos = np;
    end
    if (fw && d[6]) m_flag = 0;
    else if (set)   m_flag = 1;
    else if (sr)    m_flag = 0;
    if (fw) begin m_mode = d[7]; m_inh = d[6]; m_dly = 2; end
  endfunction

  int qlog[$], hlog[$];
  int tk;
  bit irq_seen;

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic mark();
    qlog.delete(); hlog.delete(); tk = 0; irq_seen = 0;
  endtask

  task automatic cyc(input bit t, input bit w, input bit r, input logic [5:0] a, input logic [7:0] d);
    tick = t; wr = w; rd = r; addr = a; data = d;
    @(posedge clk);
    model_step(t, w, r, a, d);
    if (t) tk++;
    #1;
    chk("q", qf, e_q);
    chk("h", hf, e_h);
    chk("irq", irq, m_flag);
    chk("mode", mode, m_mode);
    if (qf)  qlog.push_back(tk);
    if (hf)  hlog.push_back(tk);
    if (irq) irq_seen = 1;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 6'd0, 8'd0);
  endtask

  task automatic frame_write(input logic [7:0] d);
    cyc(0, 1, 0, 6'd23, d);
  endtask

  initial begin
    rst_n = 1'b0; tick = 0; wr = 0; rd = 0; addr = '0; data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", qf, 0); chk("rst_h", hf, 0); chk("rst_irq", irq, 0); chk("rst_mode", mode, 0);
    rst_n = 1'b1;

    // 4-step frame from reset
    mark();
    run_ticks(14915);
    chk("a_nq", qlog.size(), 4);
    chk("a_q1", at(qlog, 0), 3729);  chk("a_q2", at(qlog, 1), 7457);
    chk("a_q3", at(qlog, 2), 11186); chk("a_q4", at(qlog, 3), 14915);
    chk("a_nh", hlog.size(), 2);
    chk("a_h1", at(hlog, 0), 7457);  chk("a_h2", at(hlog, 1), 14915);
    chk("a_irq", irq, 1);
    cyc(0, 0, 1, 6'd21, 8'd0);
    chk("rd_clr", irq, 0);

    // wrap then write at cnt=7456: H still fires, restart one tick later
    mark();
    run_ticks(7456);
    chk("period_q", at(qlog, 0), 3729);
    frame_write(8'h00);
    mark();
    run_ticks(2);
    chk("c1_h", at(hlog, 0), 1);
    mark();
    run_ticks(7455);
    chk("c1_restart", at(qlog, 0), 3729);
    frame_write(8'h00);
    mark();
    run_ticks(2);
    chk("c2_noh", hlog.size(), 0);
    chk("c2_noq", qlog.size(), 0);

    // step-4 set coincides with status read
    mark();
    run_ticks(14914);
    cyc(1, 0, 1, 6'd21, 8'd0);
    chk("c2_restart", at(qlog, 0), 3729);
    chk("set_wins", irq, 1);

    // inhibit write clears the flag and suppresses the next IRQ
    frame_write(8'h40);
    chk("inh_clr", irq, 0);
    mark();
    run_ticks(14917);
    chk("inh_nq", qlog.size(), 4);
    chk("inh_q1", at(qlog, 0), 3731);
    chk("inh_q4", at(qlog, 3), 14917);
    chk("inh_noirq", irq_seen, 0);

    // 5-step mode
    frame_write(8'h80);
    mark();
    run_ticks(2);
    chk("m5_q0", at(qlog, 0), 2);
    chk("m5_h0", at(hlog, 0), 2);
    mark();
    run_ticks(18641);
    chk("m5_nq", qlog.size(), 4);
    chk("m5_q1", at(qlog, 0), 3729);  chk("m5_q2", at(qlog, 1), 7457);
    chk("m5_q3", at(qlog, 2), 11186); chk("m5_q4", at(qlog, 3), 18641);
    chk("m5_nh", hlog.size(), 2);
    chk("m5_h1", at(hlog, 0), 7457);  chk("m5_h2", at(hlog, 1), 18641);
    chk("m5_noirq", irq_seen, 0);

    // async reset mid-frame with a restart pending
    frame_write(8'h80);
    cyc(1, 0, 0, 6'd0, 8'd0);
    tick = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("ar_q", qf, 0); chk("ar_h", hf, 0); chk("ar_irq", irq, 0); chk("ar_mode", mode, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mark();
    run_ticks(3729);
    chk("ar_nq", qlog.size(), 1);
    chk("ar_q1", at(qlog, 0), 3729);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      bit t, w, r;
      logic [5:0] a;
      t = ($urandom_range(3) != 0);
      r = ($urandom_range(15) == 0);
      w = !r && ($urandom_range(255) == 0);
      a = 6'($urandom_range(63));
      if ((r || w) && $urandom_range(1) == 1) a = w ? 6'd23 : 6'd21;
      cyc(t, w, r, a, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
